// File: rtl/ws2812_ram_reader.sv
// ws2812_ram_reader
// Fabric-side reader for the HPS-shared 8-bit on-chip RAM. Fetches
// NUM_LEDS x 3 bytes per frame in G, R, B order, serialises them MSB first
// as a WS2812 single-wire bitstream on led_dout, then holds the line low
// for the latch time and pulses frame_done.
// Optional feature: define WS_BRIGHTNESS_EN to add a brightness[7:0] input
// that scales every fetched byte by (brightness+1)/256, sampled per frame.
module ws2812_ram_reader #(
  parameter int NUM_LEDS  = 60,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 13,
  parameter int RD_LAT    = 1,
  parameter int T0H_CYC   = 40,
  parameter int T1H_CYC   = 80,
  parameter int BIT_CYC   = 125,
  parameter int LATCH_CYC = 6000
) (
  input  logic              clk_clk,
  input  logic              rst_reset,
  input  logic              start,
`ifdef WS_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  output logic              ram_write,
  output logic [7:0]        ram_writedata,
  input  logic [7:0]        ram_readdata,
  output logic              led_dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int TW     = $clog2(BIT_CYC);
  localparam int LW     = $clog2(LATCH_CYC);
  localparam int BW     = $clog2(NBYTES);

  localparam logic [TW-1:0] T_LAST    = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] T0H_LAST  = TW'(T0H_CYC - 1);
  localparam logic [TW-1:0] T1H_LAST  = TW'(T1H_CYC - 1);
  localparam logic [LW-1:0] L_LAST    = LW'(LATCH_CYC - 1);
  localparam logic [LW-1:0] L_DONE    = LW'(LATCH_CYC - 2);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  // Elaboration-time parameter sanity checks
  if (NUM_LEDS < 1) begin : g_bad_num_leds
    $error("ws2812_ram_reader: NUM_LEDS must be >= 1");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("ws2812_ram_reader: RD_LAT must be 1 or 2");
  end
  if (longint'(BASE_ADDR) + 3 * longint'(NUM_LEDS) - 1 >= (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("ws2812_ram_reader: frame does not fit in the RAM address space");
  end
  if (T0H_CYC < 1 || T1H_CYC <= T0H_CYC || BIT_CYC <= T1H_CYC) begin : g_bad_timing
    $error("ws2812_ram_reader: need 0 < T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if (LATCH_CYC < 2) begin : g_bad_latch
    $error("ws2812_ram_reader: LATCH_CYC must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    LATCH
  } state_t;

  state_t             state;
  logic               rd_strobe;
  logic [RD_LAT-1:0]  rd_pipe;
  logic               rd_valid;
  logic [ADDR_W-1:0]  nxt_base;
  logic [1:0]         nxt_pos;
  logic [7:0]         sreg;
  logic [7:0]         pf;
  logic [7:0]         cap_byte;
  logic [2:0]         bidx;
  logic [TW-1:0]      tcnt;
  logic [LW-1:0]      lcnt;
  logic [BW-1:0]      byte_cnt;
`ifdef WS_BRIGHTNESS_EN
  logic [7:0]         br_q;
`endif

  assign ram_chipselect = rd_strobe;
  assign ram_clken      = rd_strobe;
  assign ram_write      = 1'b0;
  assign ram_writedata  = '0;
  assign rd_valid       = rd_pipe[RD_LAT-1];

  // Byte offset within an LED for read slot 0/1/2: G(+1), R(+0), B(+2)
  function automatic logic [ADDR_W-1:0] pos_off(input logic [1:0] pos);
    case (pos)
      2'd0:    return ADDR_W'(1);
      2'd1:    return '0;
      default: return ADDR_W'(2);
    endcase
  endfunction

  // Track each issued read through the RAM latency to mark its data cycle
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_strobe;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  // Returned RAM byte, optionally brightness-scaled, ready to be captured
  always_comb begin
    cap_byte = ram_readdata;
`ifdef WS_BRIGHTNESS_EN
    cap_byte = 8'((16'(ram_readdata) * (16'(br_q) + 16'd1)) >> 8);
`endif
  end

  // Frame sequencer: fetch, bit timing, prefetch, latch and status outputs
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      state       <= IDLE;
      rd_strobe   <= 1'b0;
      ram_address <= '0;
      nxt_base    <= '0;
      nxt_pos     <= '0;
      sreg        <= '0;
      pf          <= '0;
      bidx        <= '0;
      tcnt        <= '0;
      lcnt        <= '0;
      byte_cnt    <= '0;
      led_dout    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef WS_BRIGHTNESS_EN
      br_q        <= '0;
`endif
    end else begin
      rd_strobe  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          led_dout <= 1'b0;
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            rd_strobe   <= 1'b1;
            ram_address <= ADDR_W'(BASE_ADDR + 1);
            nxt_base    <= ADDR_W'(BASE_ADDR);
            nxt_pos     <= 2'd1;
            byte_cnt    <= '0;
`ifdef WS_BRIGHTNESS_EN
            br_q        <= brightness;
`endif
          end
        end

        FETCH: begin
          state <= WAIT;
        end

        WAIT: begin
          if (rd_valid) begin
            sreg     <= cap_byte;
            bidx     <= 3'd7;
            tcnt     <= '0;
            led_dout <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (rd_valid) begin
            pf <= cap_byte;
          end
          if (tcnt == T_LAST) begin
            tcnt <= '0;
            if (bidx == 3'd0) begin
              if (byte_cnt == BYTE_LAST) begin
                state    <= LATCH;
                lcnt     <= '0;
                led_dout <= 1'b0;
              end else begin
                sreg     <= pf;
                bidx     <= 3'd7;
                byte_cnt <= byte_cnt + 1'b1;
                led_dout <= 1'b1;
              end
            end else begin
              sreg     <= {sreg[6:0], 1'b0};
              bidx     <= bidx - 3'd1;
              led_dout <= 1'b1;
              // Strobe lands on the first cycle of bit 0 of the current byte
              if (bidx == 3'd1 && byte_cnt != BYTE_LAST) begin
                rd_strobe   <= 1'b1;
                ram_address <= nxt_base + pos_off(nxt_pos);
                if (nxt_pos == 2'd2) begin
                  nxt_pos  <= 2'd0;
                  nxt_base <= nxt_base + ADDR_W'(3);
                end else begin
                  nxt_pos <= nxt_pos + 2'd1;
                end
              end
            end
          end else begin
            tcnt     <= tcnt + 1'b1;
            led_dout <= (tcnt < (sreg[7] ? T1H_LAST : T0H_LAST));
          end
        end

        LATCH: begin
          lcnt     <= lcnt + 1'b1;
          led_dout <= 1'b0;
          if (lcnt == L_DONE) begin
            frame_done <= 1'b1;
          end
          if (lcnt == L_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_ram_reader.sv
// Testbench for ws2812_ram_reader: two instances (1 LED at address 0 with
// read latency 1, 3 LEDs at 0x100 with read latency 2) share one clock.
// Frames are checked cycle by cycle against a reference built from the
// RAM contents, plus table vectors and hand-written reset/start sequences.
module tb_ws2812_ram_reader;

  localparam int AW     = 13;
  localparam int BITC   = 125;
  localparam int T0H    = 40;
  localparam int T1H    = 80;
  localparam int LATC   = 6000;
  localparam int A_N    = 1;
  localparam int A_BASE = 0;
  localparam int A_LAT  = 1;
  localparam int B_N    = 3;
  localparam int B_BASE = 'h100;
  localparam int B_LAT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a, start_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          cs_a, cs_b, ce_a, ce_b, we_a, we_b;
  logic [7:0]    wd_a, wd_b, rd_a, rd_b, rd_b_p;
  logic          led_a, led_b, busy_a, busy_b, fd_a, fd_b;
`ifdef WS_BRIGHTNESS_EN
  logic [7:0]    br;
`endif

  logic [7:0] mem_a [0:(1<<AW)-1];
  logic [7:0] mem_b [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  logic          sel;
  logic          led_m, busy_m, fd_m, cs_m, ce_m, we_m;
  logic [AW-1:0] addr_m;
  assign led_m  = sel ? led_b  : led_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign fd_m   = sel ? fd_b   : fd_a;
  assign cs_m   = sel ? cs_b   : cs_a;
  assign ce_m   = sel ? ce_b   : ce_a;
  assign we_m   = sel ? we_b   : we_a;
  assign addr_m = sel ? addr_b : addr_a;

  ws2812_ram_reader #(
    .NUM_LEDS(A_N), .BASE_ADDR(A_BASE), .ADDR_W(AW), .RD_LAT(A_LAT),
    .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .LATCH_CYC(LATC)
  ) dut_a (
    .clk_clk(clk), .rst_reset(rst), .start(start_a),
`ifdef WS_BRIGHTNESS_EN
    .brightness(br),
`endif
    .ram_address(addr_a), .ram_chipselect(cs_a), .ram_clken(ce_a),
    .ram_write(we_a), .ram_writedata(wd_a), .ram_readdata(rd_a),
    .led_dout(led_a), .busy(busy_a), .frame_done(fd_a)
  );

  ws2812_ram_reader #(
    .NUM_LEDS(B_N), .BASE_ADDR(B_BASE), .ADDR_W(AW), .RD_LAT(B_LAT),
    .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .LATCH_CYC(LATC)
  ) dut_b (
    .clk_clk(clk), .rst_reset(rst), .start(start_b),
`ifdef WS_BRIGHTNESS_EN
    .brightness(br),
`endif
    .ram_address(addr_b), .ram_chipselect(cs_b), .ram_clken(ce_b),
    .ram_write(we_b), .ram_writedata(wd_b), .ram_readdata(rd_b),
    .led_dout(led_b), .busy(busy_b), .frame_done(fd_b)
  );

  // RAM models; an un-strobed cycle returns a poison byte
  always @(posedge clk) rd_a <= (cs_a && ce_a) ? mem_a[addr_a] : 8'hEE;
  always @(posedge clk) begin
    rd_b_p <= (cs_b && ce_b) ? mem_b[addr_b] : 8'hEE;
    rd_b   <= rd_b_p;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] scale(input logic [7:0] v);
`ifdef WS_BRIGHTNESS_EN
    return 8'((int'(v) * (int'(br) + 1)) / 256);
`else
    return v;
`endif
  endfunction

  logic [7:0] dec_bytes[$];
  int         rd_log[$];

  // Run one frame on the selected instance and check it against the
  // reference: per-cycle waveform, busy, frame_done, read addresses.
  task automatic run_frame(input bit use_b, input bit poke, input string tag);
    int n, lat, base, nbits, first_hi, done_k, t, hi_t;
    int wave_err, first_bad, busy_err, strobe_err, fd_cnt, fd_k;
    int prev_rise, nrise, gap_err, hi_len, nbit_dec;
    logic [7:0] exp_b[$];
    int exp_addr[$];
    logic [7:0] cur, eb;
    logic exp_led, exp_busy, prev_led;
    n    = use_b ? B_N : A_N;
    lat  = use_b ? B_LAT : A_LAT;
    base = use_b ? B_BASE : A_BASE;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 3; j++) begin
        int off;
        off = (j == 0) ? 1 : ((j == 1) ? 0 : 2);
        exp_addr.push_back(base + 3 * i + off);
        exp_b.push_back(scale(use_b ? mem_b[base + 3 * i + off] : mem_a[base + 3 * i + off]));
      end
    end
    nbits    = 24 * n;
    first_hi = lat + 2;
    done_k   = first_hi + nbits * BITC + LATC - 1;
    wave_err = 0; first_bad = -1; busy_err = 0; strobe_err = 0;
    fd_cnt = 0; fd_k = -1; prev_rise = 0; nrise = 0; gap_err = 0;
    hi_len = 0; nbit_dec = 0; cur = '0; prev_led = 1'b0;
    dec_bytes.delete();
    rd_log.delete();
    sel = use_b;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 1; k <= done_k + 5; k++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      t = k - first_hi;
      exp_led = 1'b0;
      if (t >= 0 && t < nbits * BITC) begin
        eb      = exp_b[t / (8 * BITC)];
        hi_t    = eb[7 - (t / BITC) % 8] ? T1H : T0H;
        exp_led = ((t % BITC) < hi_t);
      end
      if (led_m !== exp_led) begin
        wave_err++;
        if (first_bad < 0) first_bad = k;
      end
      exp_busy = (k <= done_k);
      if (busy_m !== exp_busy) busy_err++;
      if (fd_m === 1'b1) begin
        fd_cnt++;
        fd_k = k;
      end
      if (cs_m !== ce_m || we_m !== 1'b0) strobe_err++;
      if (cs_m === 1'b1) rd_log.push_back(int'(addr_m));
      if (led_m === 1'b1 && prev_led !== 1'b1) begin
        if (nrise > 0 && k - prev_rise != BITC) gap_err++;
        prev_rise = k;
        nrise++;
        hi_len = 0;
      end
      if (led_m === 1'b1) hi_len++;
      if (led_m !== 1'b1 && prev_led === 1'b1) begin
        cur = {cur[6:0], (hi_len > (T0H + T1H) / 2)};
        nbit_dec++;
        if (nbit_dec % 8 == 0) dec_bytes.push_back(cur);
      end
      prev_led = led_m;
      // Extra start pulses mid-SHIFT and mid-LATCH must be ignored
      if (poke && (k == first_hi + 1000 || k == done_k - 3000)) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
    end
    if (wave_err != 0) $display("  %s: first waveform deviation at cycle %0d", tag, first_bad);
    check({tag, " waveform deviations"}, wave_err, 0);
    check({tag, " busy deviations"}, busy_err, 0);
    check({tag, " strobe/write deviations"}, strobe_err, 0);
    check({tag, " frame_done count"}, fd_cnt, 1);
    check({tag, " frame_done cycle"}, fd_k, done_k);
    check({tag, " rising edges"}, nrise, nbits);
    check({tag, " bit period deviations"}, gap_err, 0);
    check({tag, " read count"}, rd_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      check($sformatf("%s read addr %0d", tag, i), (i < rd_log.size()) ? rd_log[i] : -1, exp_addr[i]);
    end
  endtask

  typedef struct {
    logic [7:0]  r, g, b;
    logic [23:0] wire_word;
  } vec_t;

  vec_t tbl[3];

  initial begin
    tbl[0] = '{8'hFF, 8'h00, 8'hA5, 24'h00FFA5};
    tbl[1] = '{8'h12, 8'h34, 8'h56, 24'h341256};
    tbl[2] = '{8'h80, 8'h01, 8'h7E, 24'h01807E};

    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    sel = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
`ifdef WS_BRIGHTNESS_EN
    br = 8'hFF;
`endif

    // Reset held three cycles: every output low
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset led_dout", {led_b, led_a}, 0);
    check("reset busy", {busy_b, busy_a}, 0);
    check("reset frame_done", {fd_b, fd_a}, 0);
    check("reset chipselect", {cs_b, cs_a}, 0);
    check("reset clken", {ce_b, ce_a}, 0);
    check("reset ram_write", {we_b, we_a}, 0);
    rst = 1'b0;

    // Table vectors on the single-LED instance
    for (int v = 0; v < 3; v++) begin
      logic [23:0] got;
      mem_a[A_BASE]     = tbl[v].r;
      mem_a[A_BASE + 1] = tbl[v].g;
      mem_a[A_BASE + 2] = tbl[v].b;
      run_frame(1'b0, 1'b0, $sformatf("vec%0d", v));
      got = (dec_bytes.size() == 3) ? {dec_bytes[0], dec_bytes[1], dec_bytes[2]} : 24'hxxxxxx;
      check($sformatf("vec%0d wire bytes", v), 32'(got), 32'(tbl[v].wire_word));
    end

    // Reset during a high phase of byte 2, then replay the frame
    mem_a[A_BASE]     = 8'hFF;
    mem_a[A_BASE + 1] = 8'h00;
    mem_a[A_BASE + 2] = 8'hA5;
    sel = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 1; k <= A_LAT + 2 + 16 * BITC + 10; k++) @(negedge clk);
    check("pre-reset led high", led_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-frame reset led_dout", led_a, 0);
    check("mid-frame reset busy", busy_a, 0);
    check("mid-frame reset chipselect", cs_a, 0);
    rst = 1'b0;
    begin
      int act;
      act = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (fd_a !== 1'b0 || busy_a !== 1'b0 || led_a !== 1'b0) act++;
      end
      check("abandoned frame stays quiet", act, 0);
    end
    run_frame(1'b0, 1'b0, "replay");

    // Randomised three-LED frame with ignored start pulses
    for (int i = 0; i < 3 * B_N; i++) mem_b[B_BASE + i] = 8'($urandom_range(0, 255));
    run_frame(1'b1, 1'b1, "rand3");
    check("rand3 last read addr", (rd_log.size() > 0) ? rd_log[rd_log.size() - 1] : -1, 'h108);
    for (int i = 0; i < B_N; i++) begin
      for (int j = 0; j < 3; j++) begin
        int off;
        logic [7:0] want;
        off  = (j == 0) ? 1 : ((j == 1) ? 0 : 2);
        want = mem_b[B_BASE + 3 * i + off];
        check($sformatf("rand3 byte %0d", 3 * i + j),
              (3 * i + j < dec_bytes.size()) ? 32'(dec_bytes[3 * i + j]) : 32'hFFFF_FFFF, 32'(want));
      end
    end

`ifdef WS_BRIGHTNESS_EN
    // Brightness: half scale and identity on an all-FF LED
    mem_a[A_BASE] = 8'hFF; mem_a[A_BASE + 1] = 8'hFF; mem_a[A_BASE + 2] = 8'hFF;
    br = 8'h7F;
    run_frame(1'b0, 1'b0, "bright7F");
    for (int i = 0; i < 3; i++)
      check("bright7F byte", (i < dec_bytes.size()) ? 32'(dec_bytes[i]) : 32'hFFFF_FFFF, 32'h7F);
    br = 8'hFF;
    run_frame(1'b0, 1'b0, "brightFF");
    for (int i = 0; i < 3; i++)
      check("brightFF byte", (i < dec_bytes.size()) ? 32'(dec_bytes[i]) : 32'hFFFF_FFFF, 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_ram_reader.md
Name: ws2812_ram_reader

Overview:
- Fabric-side reader for the HPS-shared 8-bit on-chip RAM. The HPS writes per-LED RGB bytes into this RAM; this block reads them back through the ram_* port.
- Fetches NUM_LEDS x 3 bytes per frame, reorders them to GRB and serializes them as a WS2812 single-wire bitstream on led_dout.
- Runs in the 100 MHz fabric clock domain that also clocks the RAM port.

Parameters:
- NUM_LEDS, 60, LEDs per frame; must be >= 1.
- BASE_ADDR, 0, RAM byte address of LED 0's R byte.
- ADDR_W, 13, RAM address width.
- RD_LAT, 1, RAM read latency in cycles (1 or 2).
- T0H_CYC, 40, high time of a 0 bit (0.4 us).
- T1H_CYC, 80, high time of a 1 bit (0.8 us).
- BIT_CYC, 125, total bit period (1.25 us).
- LATCH_CYC, 6000, low time after the frame (60 us).

Ports:
- clk_clk  in  1  fabric clock, 100 MHz.
- rst_reset  in  1  reset.
- start  in  1  one-cycle frame trigger.
- ram_address  out  ADDR_W  RAM byte address.
- ram_chipselect  out  1  read strobe.
- ram_clken  out  1  RAM clock enable.
- ram_write  out  1  tied 0.
- ram_writedata  out  8  tied 0.
- ram_readdata  in  8  RAM read data.
- led_dout  out  1  WS2812 data line.
- busy  out  1  high from accepted start through the end of latch.
- frame_done  out  1  one-cycle pulse at the end of latch.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high (rst_reset sampled on the rising edge of clk_clk).
  - All outputs are 0 in reset; FSM goes to IDLE.
  - Reset asserted mid-frame drives led_dout low on the next edge and abandons the frame. No frame_done pulse is generated.
- RAM layout: LED i occupies BASE_ADDR+3i (R), +3i+1 (G), +3i+2 (B).
- Read order per LED: +1, +0, +2, so the wire carries G, R, B. Bytes are sent MSB first.
- Read protocol:
  - A read is ram_chipselect=1 and ram_clken=1 with ram_address valid for exactly one cycle.
  - Data is captured exactly RD_LAT cycles later.
  - chipselect and clken are 0 at all other times.
- Elaboration check: BASE_ADDR+3*NUM_LEDS-1 must be < 2^ADDR_W, otherwise the build fails. There is no address wrap.
- FSM states: IDLE, FETCH, WAIT, SHIFT, LATCH.
  - IDLE: start=1 -> FETCH, busy=1. start while busy is ignored and not queued.
  - FETCH: issue the read of the first byte -> WAIT.
  - WAIT: count RD_LAT, load the byte into the shift register -> SHIFT.
  - SHIFT:
    - Each bit lasts BIT_CYC cycles: led_dout high for T0H_CYC or T1H_CYC, low for the remainder.
    - Prefetch: the next byte's read is issued on the first cycle of bit 0 (LSB, the last bit sent) of the current byte. It is held in a prefetch register and loaded at that bit's end.
    - There is zero gap between bytes and LEDs; every bit period is exactly BIT_CYC.
    - After bit 0 of byte 3*NUM_LEDS-1 -> LATCH.
  - LATCH: led_dout=0 for LATCH_CYC cycles. On the last cycle frame_done=1 for one cycle; next cycle busy=0 -> IDLE.
- Latency: led_dout first rises RD_LAT+2 cycles after the cycle start is sampled high.
- Counters: bit-time counter is clog2(BIT_CYC) bits, bit index is 3 bits, byte counter is clog2(3*NUM_LEDS) bits. The latch counter is separate or shares the bit-time counter widened to clog2(LATCH_CYC).
- Simultaneous start and rst_reset: reset wins.

Optional Feature:
- Macro WS_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness [7:0].
  - Each fetched byte is scaled to (byte*(brightness+1))>>8 before shifting.
  - brightness is sampled once per frame, on the cycle start is accepted.
  - 0xFF is identity; 0x00 yields all-zero bytes.
- When undefined: no brightness port; bytes are sent unmodified.

Test Plan:
- Reset: hold rst_reset 3 cycles -> led_dout, busy, frame_done, ram_chipselect, ram_clken all 0; ram_write stays 0 throughout.
- NUM_LEDS=1, RAM[0..2]=FF,00,A5, pulse start ->
  - read addresses are 1, 0, 2, in that order.
  - Wire carries 00 FF A5: eight 40-cycle highs, eight 80-cycle highs, then the pattern 1,0,1,0,0,1,0,1; each bit is 125 cycles.
  - Then 6000 cycles low, frame_done pulses once, busy falls the next cycle.
- NUM_LEDS=3, BASE_ADDR=0x100 ->
  - last read address is 0x108 (+1,+0,+2 order per LED).
  - Rising edges are exactly 125 cycles apart across all byte and LED boundaries; 72 bits total.
- start pulsed again mid-SHIFT and mid-LATCH -> no effect on stream or addresses; exactly one frame_done.
- rst_reset asserted during a high phase of byte 2 -> led_dout 0 next cycle; no frame_done; a new start afterwards replays the frame from BASE_ADDR+1.
- WS_BRIGHTNESS_EN, brightness=0x7F, all bytes FF -> every byte sent is 0x7F; brightness=0xFF -> 0xFF sent.
